arith_extend_stream: RTL and testbench
======================================

Name: arith_extend_stream

Overview:
- Multi-channel width converter (DEPTH lanes, IN_W to OUT_W) behind an elastic valid/ready pipeline of STAGES registers.
- Per-lane signed/unsigned selection.
- Supports widening (sign/zero extend) and narrowing (truncate, with overflow detect and optional saturation).
- Sits between datapath producers (loads, immediates, ALU results) and consumers that may stall.

Parameters:
IN_W, 16, input lane width in bits (>=1)
OUT_W, 32, output lane width in bits (>=1; may be <, = or > IN_W)
DEPTH, 2, number of parallel lanes sharing one handshake
STAGES, 2, pipeline register stages (1..4); latency in cycles

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_data  in  DEPTH x IN_W  input lanes
in_sign  in  DEPTH x Arith_SignedUnsigned_T  per-lane signedness, sampled with in_data
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
out_data  out  DEPTH x OUT_W  converted lanes
out_ovf  out  DEPTH  per-lane overflow flag accompanying out_data
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
ovf_sticky  out  DEPTH  per-lane sticky overflow
ovf_clear  in  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits, data, out_ovf and ovf_sticky go to 0. in_ready is forced to 0 while reset_n is low. First beat is accepted on the first rising edge after reset_n rises.
- Conversion (combinational, before stage 1), per lane:
  - OUT_W > IN_W: signed replicates in_data MSB; unsigned zero-fills. ovf = 0.
  - OUT_W == IN_W: passthrough. ovf = 0.
  - OUT_W < IN_W: result = low OUT_W bits.
    - Signed: ovf = 1 if the discarded bits differ from the sign-extension of result MSB.
    - Unsigned: ovf = 1 if any discarded bit is 1.
- Pipeline: stage i holds valid v[i], DEPTH lanes of data, and DEPTH ovf bits.
  - rdy[STAGES] = out_ready; rdy[i] = !v[i] || rdy[i+1]; in_ready = rdy[1] (combinational chain).
  - A stage loads when its rdy is high. It loads v from the upstream handshake (in_valid for stage 1).
  - Stage data is held while stalled.
- Latency: exactly STAGES cycles from accepted input to out_valid when not stalled. Full throughput is one beat per cycle.
- Back-pressure: the pipeline absorbs up to STAGES beats with out_ready low, then in_ready drops. No beat is lost or duplicated. Order is preserved.
- out_data/out_ovf are stable while out_valid && !out_ready.
- Sticky: ovf_sticky[k] sets on the cycle a beat with out_ovf[k]=1 completes the output handshake. ovf_clear clears all lanes. If clear and set coincide, set wins.
- Reset mid-operation discards all in-flight beats. Nothing is emitted for them.

Optional Feature:
ARITH_EXTEND_STREAM_SAT_EN
- Defined: on narrowing overflow, the result clamps.
  - Signed: positive to 0 followed by ones (max); negative to 1 followed by zeros (min).
  - Unsigned: all ones.
  - out_ovf still reports the event.
- Undefined: the result is the truncated low bits, and out_ovf reports the event. Widening and equal-width behaviour is identical either way.

Decomposition:
- Shared package: Arith_SignedUnsigned_T encoding (Signed/Unsigned). It is reused unchanged.
- New shared constant: ARITH_EXTEND_STAGES_MAX = 4.
- One sub-module: arith_extend_lane. It is combinational, single lane, parameters IN_W/OUT_W, and produces result + ovf including the saturation path. It is instantiated DEPTH times.
- Pipeline registers stay in the top module.

Test Plan:
- IN_W=4 OUT_W=8 DEPTH=2 STAGES=2, signed, in {0xa,0x5}, out_ready=1: out {0xfa,0x05} valid exactly 2 cycles after acceptance; ovf {0,0}.
- Same config, lane0 unsigned, lane1 signed, in {0xa,0xa}: out {0x0a,0xfa}.
- IN_W=8 OUT_W=4, signed, in {0x7f,0xf9}:
  - SAT_EN undefined: out {0xf,0x9}, ovf {1,0}.
  - SAT_EN defined: out {0x7,0x9}, ovf {1,0}.
  - Unsigned 0x10 gives ovf=1, out 0x0 (no SAT) or 0xf (SAT).
- Back-pressure, STAGES=2: drive 4 consecutive beats 1,2,3,4 with out_ready low for 3 cycles.
  - in_ready goes low after 2 beats are held.
  - Output sequence is 1,2,3,4 with no gaps once out_ready goes high.
- Sticky: an overflow beat is accepted on the same cycle as ovf_clear=1, so ovf_sticky=1. ovf_clear alone the next cycle gives ovf_sticky=0.
- Assert reset_n low asynchronously mid-clock with 2 beats in flight: out_valid and ovf_sticky drop immediately. No stale beat appears after release. in_ready=0 during reset and 1 after.

Source files
------------

// File: rtl/arith_extend_stream_pkg.sv
// Shared types and constants for the arith_extend_stream width converter.
// Signedness encoding is shared with other datapath blocks and must not change.
package arith_extend_stream_pkg;

    typedef enum logic {
        ARITH_UNSIGNED = 1'b0,
        ARITH_SIGNED   = 1'b1
    } Arith_SignedUnsigned_T;

    localparam int ARITH_EXTEND_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        CONV_WIDEN  = 2'd0,
        CONV_EQUAL  = 2'd1,
        CONV_NARROW = 2'd2
    } conv_kind_e;

    function automatic conv_kind_e conv_kind(input int in_w, input int out_w);
        if (out_w > in_w) begin
            return CONV_WIDEN;
        end else if (out_w == in_w) begin
            return CONV_EQUAL;
        end
        return CONV_NARROW;
    endfunction

    // Legal stage counts are 1..ARITH_EXTEND_STAGES_MAX; out-of-range values are clamped.
    function automatic int clamp_stages(input int stages);
        if (stages < 1) begin
            return 1;
        end else if (stages > ARITH_EXTEND_STAGES_MAX) begin
            return ARITH_EXTEND_STAGES_MAX;
        end
        return stages;
    endfunction

endpackage

// File: rtl/arith_extend_stream_if.sv
// Stream bundle for arith_extend_stream: input beat, output beat and sticky overflow.
// The converter uses the slave view; the producer/consumer side uses master.
interface arith_extend_stream_if
    import arith_extend_stream_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) ();

    logic [DEPTH-1:0][IN_W-1:0]        in_data;
    Arith_SignedUnsigned_T [DEPTH-1:0] in_sign;
    logic                              in_valid;
    logic                              in_ready;

    logic [DEPTH-1:0][OUT_W-1:0]       out_data;
    logic [DEPTH-1:0]                  out_ovf;
    logic                              out_valid;
    logic                              out_ready;

    logic [DEPTH-1:0]                  ovf_sticky;
    logic                              ovf_clear;

    modport slave (
        input  in_data,
        input  in_sign,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_ovf,
        output out_valid,
        input  out_ready,
        output ovf_sticky,
        input  ovf_clear
    );

    modport master (
        output in_data,
        output in_sign,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_ovf,
        input  out_valid,
        output out_ready,
        input  ovf_sticky,
        output ovf_clear
    );

endinterface

// File: rtl/arith_extend_stream_lane.sv
// Single-lane combinational width converter (extend, pass or truncate with overflow).
// Build option ARITH_EXTEND_STREAM_SAT_EN clamps narrowing overflows instead of wrapping.
module arith_extend_lane
    import arith_extend_stream_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]       data,
    input  Arith_SignedUnsigned_T sign,
    output logic [OUT_W-1:0]      result,
    output logic                  ovf
);

    localparam conv_kind_e KIND = conv_kind(IN_W, OUT_W);

    generate
        if (KIND == CONV_WIDEN) begin : g_widen
            localparam int EXT_W = OUT_W - IN_W;
            logic fill;

            assign fill   = (sign == ARITH_SIGNED) & data[IN_W-1];
            assign result = {{EXT_W{fill}}, data};
            assign ovf    = 1'b0;
        end else if (KIND == CONV_EQUAL) begin : g_equal
            logic unused_sign;

            assign unused_sign = (sign == ARITH_SIGNED);
            assign result      = data;
            assign ovf         = 1'b0;
        end else begin : g_narrow
            localparam int DROP_W = IN_W - OUT_W;
            logic [OUT_W-1:0]  low;
            logic [DROP_W-1:0] drop;
            logic              is_signed;
            logic              ovf_signed;
            logic              ovf_unsigned;

            assign low          = data[OUT_W-1:0];
            assign drop         = data[IN_W-1:OUT_W];
            assign is_signed    = (sign == ARITH_SIGNED);
            // Signed value fits only if the dropped bits are copies of the kept MSB.
            assign ovf_signed   = (drop != {DROP_W{low[OUT_W-1]}});
            assign ovf_unsigned = |drop;
            assign ovf          = is_signed ? ovf_signed : ovf_unsigned;

`ifdef ARITH_EXTEND_STREAM_SAT_EN
            logic [OUT_W-1:0] sat_max;
            logic [OUT_W-1:0] clamp;

            // Shift form keeps OUT_W == 1 legal (signed max is then 0).
            assign sat_max = {OUT_W{1'b1}} >> 1;

            always_comb begin
                clamp = '1;
                if (is_signed) begin
                    clamp = data[IN_W-1] ? ~sat_max : sat_max;
                end
            end

            assign result = ovf ? clamp : low;
`else
            assign result = low;
`endif
        end
    endgenerate

endmodule

// File: rtl/arith_extend_stream.sv
// DEPTH-lane width converter followed by an elastic valid/ready pipeline of STAGES registers.
// Optional clamping on narrowing overflow: ARITH_EXTEND_STREAM_SAT_EN (see arith_extend_lane).
module arith_extend_stream
    import arith_extend_stream_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 2,
    parameter int STAGES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    arith_extend_stream_if.slave bus
);

    localparam int NSTG = clamp_stages(STAGES);

    typedef logic [DEPTH-1:0][OUT_W-1:0] lanes_t;

    lanes_t           conv_data;
    logic [DEPTH-1:0] conv_ovf;

    logic [NSTG-1:0]  stg_valid;
    lanes_t           stg_data [NSTG];
    logic [DEPTH-1:0] stg_ovf  [NSTG];
    logic [NSTG:0]    rdy;

    logic             out_fire;
    logic [DEPTH-1:0] sticky;

    for (genvar k = 0; k < DEPTH; k++) begin : g_lane
        arith_extend_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .data   (bus.in_data[k]),
            .sign   (bus.in_sign[k]),
            .result (conv_data[k]),
            .ovf    (conv_ovf[k])
        );
    end

    // Ready ripples back from the consumer; an empty stage always accepts.
    always_comb begin
        rdy       = '0;
        rdy[NSTG] = bus.out_ready;
        for (int s = NSTG - 1; s >= 0; s--) begin
            rdy[s] = !stg_valid[s] || rdy[s+1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= '0;
            for (int s = 0; s < NSTG; s++) begin
                stg_data[s] <= '0;
                stg_ovf[s]  <= '0;
            end
        end else begin
            if (rdy[0]) begin
                stg_valid[0] <= bus.in_valid;
                stg_data[0]  <= conv_data;
                stg_ovf[0]   <= conv_ovf;
            end
            for (int s = 1; s < NSTG; s++) begin
                if (rdy[s]) begin
                    stg_valid[s] <= stg_valid[s-1];
                    stg_data[s]  <= stg_data[s-1];
                    stg_ovf[s]   <= stg_ovf[s-1];
                end
            end
        end
    end

    assign out_fire = stg_valid[NSTG-1] & bus.out_ready;

    // A completing overflow beat takes priority over a coincident clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky <= '0;
        end else begin
            sticky <= (bus.ovf_clear ? '0 : sticky)
                    | (out_fire ? stg_ovf[NSTG-1] : '0);
        end
    end

    assign bus.in_ready   = rdy[0] & reset_n;
    assign bus.out_valid  = stg_valid[NSTG-1];
    assign bus.out_data   = stg_data[NSTG-1];
    assign bus.out_ovf    = stg_ovf[NSTG-1];
    assign bus.ovf_sticky = sticky;

endmodule

// File: tb/tb_arith_extend_stream.sv
// Bench for arith_extend_stream: a widening (4->8) and a narrowing (8->4) instance
// checked every cycle against a queue-based arithmetic model, plus directed scenarios.
module tb_arith_extend_stream;
    import arith_extend_stream_pkg::*;

    localparam int STAGES = 2;

    typedef struct {
        logic [1:0][7:0] data;
        logic [1:0]      ovf;
        int              cyc;
    } beat_t;

    logic clock;
    logic reset_n;

    logic [1:0][7:0] drv_data  [2];
    logic [1:0]      drv_sign  [2];
    logic            drv_valid [2];
    logic            drv_ready [2];
    logic            drv_clear [2];

    logic [1:0][7:0] mo_data   [2];
    logic [1:0]      mo_ovf    [2];
    logic [1:0]      mo_sticky [2];
    logic            mo_valid  [2];
    logic            mo_iready [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    beat_t      q [2][$];
    logic [1:0] sticky_m [2];
    beat_t      nb;
    logic [8:0] m;
    bit         exp_valid;
    bit         exp_ir;
    bit         fire_out;

    arith_extend_stream_if #(.IN_W(4), .OUT_W(8), .DEPTH(2)) ifw ();
    arith_extend_stream_if #(.IN_W(8), .OUT_W(4), .DEPTH(2)) ifn ();

    arith_extend_stream #(.IN_W(4), .OUT_W(8), .DEPTH(2), .STAGES(STAGES)) dut_w (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifw.slave)
    );

    arith_extend_stream #(.IN_W(8), .OUT_W(4), .DEPTH(2), .STAGES(STAGES)) dut_n (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifn.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            ifw.in_data[k] = drv_data[0][k][3:0];
            ifw.in_sign[k] = drv_sign[0][k] ? ARITH_SIGNED : ARITH_UNSIGNED;
            ifn.in_data[k] = drv_data[1][k];
            ifn.in_sign[k] = drv_sign[1][k] ? ARITH_SIGNED : ARITH_UNSIGNED;
            mo_data[0][k]  = ifw.out_data[k];
            mo_data[1][k]  = {4'b0000, ifn.out_data[k]};
        end
        ifw.in_valid  = drv_valid[0];
        ifw.out_ready = drv_ready[0];
        ifw.ovf_clear = drv_clear[0];
        ifn.in_valid  = drv_valid[1];
        ifn.out_ready = drv_ready[1];
        ifn.ovf_clear = drv_clear[1];
        mo_ovf[0]     = ifw.out_ovf;
        mo_ovf[1]     = ifn.out_ovf;
        mo_sticky[0]  = ifw.ovf_sticky;
        mo_sticky[1]  = ifn.ovf_sticky;
        mo_valid[0]   = ifw.out_valid;
        mo_valid[1]   = ifn.out_valid;
        mo_iready[0]  = ifw.in_ready;
        mo_iready[1]  = ifn.in_ready;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Convert as integers: interpret, test range, optionally clamp, then wrap. Returns {ovf, result}.
    function automatic logic [8:0] model(input int iw, input int ow, input logic [7:0] x, input bit sgn);
        int v, lo, hi, r;
        bit ovf;
        v = int'(x) & ((1 << iw) - 1);
        if (sgn && v >= (1 << (iw - 1))) v -= (1 << iw);
        if (sgn) begin
            lo = -(1 << (ow - 1));
            hi = (1 << (ow - 1)) - 1;
        end else begin
            lo = 0;
            hi = (1 << ow) - 1;
        end
        ovf = (v < lo) || (v > hi);
        r = v;
`ifdef ARITH_EXTEND_STREAM_SAT_EN
        if (v < lo) r = lo;
        else if (v > hi) r = hi;
`endif
        return {ovf, 8'(r & ((1 << ow) - 1))};
    endfunction

    function automatic int iw_of(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int ow_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    always @(negedge clock) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                q[d].delete();
                sticky_m[d] = '0;
                chk("rst_in_ready", mo_iready[d], 0);
                chk("rst_out_valid", mo_valid[d], 0);
                chk("rst_sticky", mo_sticky[d], 0);
            end else begin
                exp_valid = (q[d].size() > 0) && ((cyc - q[d][0].cyc) >= STAGES);
                exp_ir    = (q[d].size() < STAGES) || drv_ready[d];
                chk($sformatf("sticky[%0d]", d), mo_sticky[d], sticky_m[d]);
                chk($sformatf("in_ready[%0d]", d), mo_iready[d], exp_ir);
                chk($sformatf("out_valid[%0d]", d), mo_valid[d], exp_valid);
                if (exp_valid && mo_valid[d]) begin
                    chk($sformatf("out_data[%0d]", d), mo_data[d], q[d][0].data);
                    chk($sformatf("out_ovf[%0d]", d), mo_ovf[d], q[d][0].ovf);
                end
                fire_out = exp_valid && drv_ready[d];
                sticky_m[d] = (drv_clear[d] ? 2'b00 : sticky_m[d]) | (fire_out ? q[d][0].ovf : 2'b00);
                if (fire_out) void'(q[d].pop_front());
                if (drv_valid[d] && exp_ir) begin
                    for (int k = 0; k < 2; k++) begin
                        m = model(iw_of(d), ow_of(d), drv_data[d][k], drv_sign[d][k]);
                        nb.data[k] = m[7:0];
                        nb.ovf[k]  = m[8];
                    end
                    nb.cyc = cyc;
                    q[d].push_back(nb);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            drv_valid[d] = 1'b0;
            drv_clear[d] = 1'b0;
            drv_ready[d] = 1'b1;
            drv_data[d]  = '0;
            drv_sign[d]  = '0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish (got timeout want finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_all();

        // Pin the model with hand-computed results.
        chk("model_w_sext", model(4, 8, 8'h0a, 1'b1), 9'h0fa);
        chk("model_w_zext", model(4, 8, 8'h0a, 1'b0), 9'h00a);
        chk("model_n_neg_ok", model(8, 4, 8'hf9, 1'b1), 9'h009);
`ifdef ARITH_EXTEND_STREAM_SAT_EN
        chk("model_n_pos_ovf", model(8, 4, 8'h7f, 1'b1), 9'h107);
        chk("model_n_u_ovf", model(8, 4, 8'h10, 1'b0), 9'h10f);
`else
        chk("model_n_pos_ovf", model(8, 4, 8'h7f, 1'b1), 9'h10f);
        chk("model_n_u_ovf", model(8, 4, 8'h10, 1'b0), 9'h100);
`endif

        repeat (2) step();
        chk("in_ready_in_reset", mo_iready[0], 0);
        reset_n = 1'b1;
        #1;
        chk("in_ready_after_reset", mo_iready[0], 1);

        // Widening, signed both lanes: exact two-cycle latency.
        drv_data[0] = {8'h05, 8'h0a};
        drv_sign[0] = 2'b11;
        drv_valid[0] = 1'b1;
        step();
        drv_valid[0] = 1'b0;
        chk("lat_not_early", mo_valid[0], 0);
        step();
        chk("lat_valid", mo_valid[0], 1);
        chk("w_signed_data", mo_data[0], 16'h05fa);
        chk("w_signed_ovf", mo_ovf[0], 0);
        step();

        // Mixed signedness: lane0 unsigned, lane1 signed.
        drv_data[0] = {8'h0a, 8'h0a};
        drv_sign[0] = 2'b10;
        drv_valid[0] = 1'b1;
        step();
        drv_valid[0] = 1'b0;
        step();
        chk("w_mixed_data", mo_data[0], 16'hfa0a);
        step();

        // Narrowing signed.
        drv_data[1] = {8'hf9, 8'h7f};
        drv_sign[1] = 2'b11;
        drv_valid[1] = 1'b1;
        step();
        drv_valid[1] = 1'b0;
        step();
`ifdef ARITH_EXTEND_STREAM_SAT_EN
        chk("n_signed_data", mo_data[1], 16'h0907);
`else
        chk("n_signed_data", mo_data[1], 16'h090f);
`endif
        chk("n_signed_ovf", mo_ovf[1], 2'b01);
        step();

        // Narrowing unsigned overflow.
        drv_data[1] = {8'h10, 8'h10};
        drv_sign[1] = 2'b00;
        drv_valid[1] = 1'b1;
        step();
        drv_valid[1] = 1'b0;
        step();
`ifdef ARITH_EXTEND_STREAM_SAT_EN
        chk("n_unsigned_data", mo_data[1], 16'h0f0f);
`else
        chk("n_unsigned_data", mo_data[1], 16'h0000);
`endif
        chk("n_unsigned_ovf", mo_ovf[1], 2'b11);
        repeat (3) step();

        // Back-pressure: two beats absorbed, third held off, then gap-free drain.
        drv_ready[0] = 1'b0;
        drv_sign[0]  = 2'b00;
        drv_valid[0] = 1'b1;
        drv_data[0]  = {8'h01, 8'h01};
        chk("bp_accept1", mo_iready[0], 1);
        step();
        drv_data[0]  = {8'h02, 8'h02};
        step();
        drv_data[0]  = {8'h03, 8'h03};
        chk("bp_full", mo_iready[0], 0);
        step();
        drv_ready[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) drv_data[0] = {8'h04, 8'h04};
            if (i == 3) drv_valid[0] = 1'b0;
            chk($sformatf("bp_valid_%0d", i), mo_valid[0], 1);
            chk($sformatf("bp_order_%0d", i), mo_data[0][0], i);
            step();
        end
        chk("bp_drained", mo_valid[0], 0);
        repeat (2) step();

        // Sticky: set coinciding with clear wins; clear alone then empties it.
        drv_data[1] = {8'h10, 8'h10};
        drv_sign[1] = 2'b00;
        drv_valid[1] = 1'b1;
        step();
        drv_valid[1] = 1'b0;
        step();
        drv_clear[1] = 1'b1;
        chk("sticky_beat_present", mo_valid[1], 1);
        step();
        chk("sticky_set_wins", mo_sticky[1], 2'b11);
        step();
        chk("sticky_cleared", mo_sticky[1], 2'b00);
        drv_clear[1] = 1'b0;
        step();

        // Randomized traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                drv_valid[d] = ($urandom_range(0, 3) != 0);
                drv_data[d]  = {8'($urandom), 8'($urandom)};
                drv_sign[d]  = 2'($urandom);
                drv_ready[d] = ($urandom_range(0, 3) != 0);
                drv_clear[d] = ($urandom_range(0, 15) == 0);
            end
            step();
        end
        idle_all();
        repeat (4) step();

        // Asynchronous reset with beats in flight.
        drv_data[1] = {8'h10, 8'h10};
        drv_valid[1] = 1'b1;
        step();
        drv_valid[1] = 1'b0;
        repeat (2) step();
        chk("pre_rst_sticky", mo_sticky[1], 2'b11);
        for (int d = 0; d < 2; d++) begin
            drv_ready[d] = 1'b0;
            drv_valid[d] = 1'b1;
        end
        drv_data[0] = {8'h07, 8'h03};
        repeat (2) step();
        drv_valid[0] = 1'b0;
        drv_valid[1] = 1'b0;
        chk("pre_rst_valid", mo_valid[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid_w", mo_valid[0], 0);
        chk("async_rst_valid_n", mo_valid[1], 0);
        chk("async_rst_sticky", mo_sticky[1], 0);
        chk("async_rst_in_ready", mo_iready[0], 0);
        repeat (2) step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready_w", mo_iready[0], 1);
        chk("post_rst_in_ready_n", mo_iready[1], 1);
        drv_ready[0] = 1'b1;
        drv_ready[1] = 1'b1;
        repeat (6) step();
        chk("no_stale_beat", mo_valid[0] | mo_valid[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
